// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit execution stage: opcodes, widths,
// instruction field positions and the bundled ALU result type.
package alu_pkg;

  localparam int OP_W    = 4;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = OP_W + 2 * DATA_W;

  // Instruction layout {op, A, B}
  localparam int OP_MSB = 19;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 8;
  localparam int B_MSB  = 7;
  localparam int B_LSB  = 0;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XNOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b0111;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              c;
    logic              v;
    logic              n;
    logic              z;
  } alu_out_t;

endpackage

// File: rtl/alu8_core.sv
// Purely combinational 8-bit ALU: decodes the opcode and produces the
// result plus C/V/N/Z flags. Reserved opcodes yield an all-zero result.
module alu8_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output alu_out_t          res
);

  logic [DATA_W:0]   sum9;
  logic [DATA_W:0]   diff9;
  logic [DATA_W:0]   shl9;
  logic [3:0]        k;
  logic [DATA_W-1:0] y;
  logic              c;
  logic              v;

  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    // Bit 8 of the 9-bit difference is set exactly when A < B (borrow)
    diff9 = {1'b0, a} - {1'b0, b};
    k     = b[7:4];
    // Shifting in 9 bits leaves A[8-k] in bit 8 for k=1..8, zero otherwise
    shl9  = {1'b0, a} << k;

    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        y = sum9[DATA_W-1:0];
        c = sum9[DATA_W];
        v = (a[7] == b[7]) && (sum9[7] != a[7]);
      end
      OP_SUB: begin
        y = diff9[DATA_W-1:0];
        c = diff9[DATA_W];
        v = (a[7] != b[7]) && (diff9[7] != a[7]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_XNOR: y = ~(a ^ b);
      OP_SHL: begin
        y = shl9[DATA_W-1:0];
        c = shl9[DATA_W];
      end
      default: begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
      end
    endcase

    res.y = y;
    res.c = c;
    res.v = v;
    res.n = y[DATA_W-1];
    res.z = (y == '0);
  end

endmodule

// File: rtl/control_unit.sv
// Execution stage: splits the instruction into fields, runs the ALU and
// registers result and flags. No handshake; one instruction per clock.
module control_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [DATA_W-1:0]  Y,
  output logic               C,
  output logic               V,
  output logic               N,
  output logic               Z
);

  logic [OP_W-1:0]   op;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  alu_out_t          alu_res;

  assign op = INSTR[OP_MSB:OP_LSB];
  assign a  = INSTR[A_MSB:A_LSB];
  assign b  = INSTR[B_MSB:B_LSB];

  alu8_core u_core (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (alu_res)
  );

  // Every output comes straight from a flop; INSTR never reaches a port combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y <= '0;
      C <= 1'b0;
      V <= 1'b0;
      N <= 1'b0;
      Z <= 1'b0;
    end else begin
      Y <= alu_res.y;
      C <= alu_res.c;
      V <= alu_res.v;
      N <= alu_res.n;
      Z <= alu_res.z;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed and random checks of control_unit: every issued instruction
// queues its expected {Y,C,V,N,Z}, which is popped one edge later.
module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [19:0] INSTR;
  logic [7:0]  Y;
  logic        C;
  logic        V;
  logic        N;
  logic        Z;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .INSTR (INSTR),
    .Y     (Y),
    .C     (C),
    .V     (V),
    .N     (N),
    .Z     (Z)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pk(input logic [7:0] y, input logic c,
                                     input logic v, input logic n, input logic z);
    return {y, c, v, n, z};
  endfunction

  // Reference model written from the opcode table with integer arithmetic
  function automatic logic [11:0] model(input logic [19:0] ins);
    int          ai;
    int          bi;
    int          r;
    int          k;
    logic [7:0]  av;
    logic [7:0]  y;
    logic        c;
    logic        v;
    av = ins[15:8];
    ai = int'(ins[15:8]);
    bi = int'(ins[7:0]);
    k  = int'(ins[7:4]);
    y  = 8'h00;
    c  = 1'b0;
    v  = 1'b0;
    case (int'(ins[19:16]))
      0: begin
        r = ai + bi;
        y = r[7:0];
        c = (r > 255);
        v = (ins[15] == ins[7]) && (y[7] != ins[15]);
      end
      1: begin
        r = ai - bi;
        y = r[7:0];
        c = (ai < bi);
        v = (ins[15] != ins[7]) && (y[7] != ins[15]);
      end
      2: y = ins[15:8] & ins[7:0];
      3: y = ins[15:8] | ins[7:0];
      4: y = ins[15:8] ^ ins[7:0];
      5: y = ~ins[15:8];
      6: y = ~(ins[15:8] ^ ins[7:0]);
      7: begin
        r = (ai * (1 << k)) % 256;
        y = (k >= 8) ? 8'h00 : r[7:0];
        c = (k >= 1 && k <= 8) ? av[8-k] : 1'b0;
      end
      default: y = 8'h00;
    endcase
    return pk(y, c, v, y[7], (y == 8'h00));
  endfunction

  // Scoreboard: pop the oldest expectation and compare against the outputs
  task automatic check_out(input string tag);
    logic [11:0] got;
    logic [11:0] exp;
    got = {Y, C, V, N, Z};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s got=%h exp=<empty queue>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        bad++;
        $error("FAIL %s got={Y=%h CVNZ=%b} exp={Y=%h CVNZ=%b}", tag,
               got[11:4], got[3:0], exp[11:4], exp[3:0]);
      end
    end
  endtask

  task automatic check_reset(input string tag);
    logic [11:0] got;
    got = {Y, C, V, N, Z};
    total++;
    assert (got === 12'h000) else begin
      bad++;
      $error("FAIL %s got={Y=%h CVNZ=%b} exp={Y=00 CVNZ=0000}", tag, got[11:4], got[3:0]);
    end
  endtask

  // driver: present at negedge, result checked just after the next posedge
  task automatic step(input string tag, input logic [19:0] ins, input logic [11:0] exp);
    @(negedge clk);
    INSTR = ins;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic step_rand(input string tag, input logic [19:0] ins);
    step(tag, ins, model(ins));
  endtask

  initial begin
    logic [19:0] ins;
    rst_n = 1'b0;
    INSTR = 20'h0_28_14;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_initial");

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(pk(8'h3C, 0, 0, 0, 0));
    check_out("first_after_release");

    step("add_f0_14",  20'h0_F0_14, pk(8'h04, 1, 0, 0, 0));
    step("add_ba_b0",  20'h0_BA_B0, pk(8'h6A, 1, 1, 0, 0));
    step("sub_1e_14",  20'h1_1E_14, pk(8'h0A, 0, 0, 0, 0));
    step("sub_3c_50",  20'h1_3C_50, pk(8'hEC, 1, 0, 1, 0));
    step("sub_1e_1e",  20'h1_1E_1E, pk(8'h00, 0, 0, 0, 1));
    step("and_11_33",  20'h2_11_33, pk(8'h11, 0, 0, 0, 0));
    step("or_11_33",   20'h3_11_33, pk(8'h33, 0, 0, 0, 0));
    step("xor_11_33",  20'h4_11_33, pk(8'h22, 0, 0, 0, 0));
    step("not_11",     20'h5_11_33, pk(8'hEE, 0, 0, 1, 0));
    step("xnor_11_33", 20'h6_11_33, pk(8'hDD, 0, 0, 1, 0));
    step("shl_k0",     20'h7_FF_00, pk(8'hFF, 0, 0, 1, 0));
    step("shl_k1",     20'h7_FF_10, pk(8'hFE, 1, 0, 1, 0));
    step("shl_k8",     20'h7_81_80, pk(8'h00, 1, 0, 0, 1));
    step("shl_k11",    20'h7_FF_B0, pk(8'h00, 0, 0, 0, 1));
    step("shl_k15",    20'h7_FF_F0, pk(8'h00, 0, 0, 0, 1));
    step("reserved_8", 20'h8_11_33, pk(8'h00, 0, 0, 0, 1));
    step("reserved_f", 20'hF_FF_FF, pk(8'h00, 0, 0, 0, 1));

    // back-to-back random stream, one instruction per cycle
    for (int i = 0; i < 40; i++) begin
      ins = {4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      step_rand("rand_stream", ins);
    end

    // async reset mid-operation: outputs clear with no clock edge
    @(negedge clk);
    INSTR = 20'h0_F0_14;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async_no_edge");
    @(posedge clk);
    #1;
    check_reset("reset_held_over_edge");

    @(negedge clk);
    rst_n = 1'b1;
    INSTR = 20'h0_28_14;
    @(posedge clk);
    #1;
    exp_q.push_back(pk(8'h3C, 0, 0, 0, 0));
    check_out("add_after_rerelease");

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drained got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
